// File: rtl/counter_block_pkg.sv
// counter_block_pkg: shared widths and types for the keystream counter block
package counter_block_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_WIDTH = 16;
  typedef logic [WIDTH-1:0] ctr_t;
  typedef logic [CNT_WIDTH-1:0] blk_cnt_t;
endpackage

// File: rtl/counter_block_next.sv
// counter_block_next: combinational next-counter mux/adder (load, increment, hold) and wrap condition; wrap_hit exists only with COUNTER_BLOCK_WRAP_DETECT_EN
// Ports: key, prev_value, enable, new_message in; counter_next out; wrap_hit out when wrap detection is built.
module counter_block_next
  import counter_block_pkg::*;
#(
  parameter int WIDTH = counter_block_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] prev_value,
  input  logic             enable,
  input  logic             new_message,
`ifdef COUNTER_BLOCK_WRAP_DETECT_EN
  output logic             wrap_hit,
`endif
  output logic [WIDTH-1:0] counter_next
);
  always_comb counter_next = !enable ? prev_value : new_message ? key : prev_value + WIDTH'(1);
`ifdef COUNTER_BLOCK_WRAP_DETECT_EN
  always_comb wrap_hit = enable && !new_message && (&prev_value);
`endif
endmodule

// File: rtl/counter_block.sv
// counter_block: keystream counter generator with registered counter, saturating per-message block count and optional wrap pulse (COUNTER_BLOCK_WRAP_DETECT_EN)
// Ports: clk, rst_n (async active-low), key, prev_value, enable, new_message in; counter_next (comb), counter_q, block_cnt, wrap out.
module counter_block
  import counter_block_pkg::*;
#(
  parameter int WIDTH = counter_block_pkg::WIDTH,
  parameter int CNT_WIDTH = counter_block_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     key,
  input  logic [WIDTH-1:0]     prev_value,
  input  logic                 enable,
  input  logic                 new_message,
  output logic [WIDTH-1:0]     counter_next,
  output logic [WIDTH-1:0]     counter_q,
  output logic [CNT_WIDTH-1:0] block_cnt,
  output logic                 wrap
);
`ifdef COUNTER_BLOCK_WRAP_DETECT_EN
  logic wrap_hit;
`endif
  counter_block_next #(.WIDTH(WIDTH)) u_next (
    .key(key),
    .prev_value(prev_value),
    .enable(enable),
    .new_message(new_message),
`ifdef COUNTER_BLOCK_WRAP_DETECT_EN
    .wrap_hit(wrap_hit),
`endif
    .counter_next(counter_next)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      counter_q <= '0;
      block_cnt <= '0;
    end else if (enable) begin
      counter_q <= counter_next;
      block_cnt <= new_message ? CNT_WIDTH'(1) : (&block_cnt) ? block_cnt : block_cnt + CNT_WIDTH'(1);
    end
`ifdef COUNTER_BLOCK_WRAP_DETECT_EN
  // wrap is a pulse, so it clears on the next edge even when enable is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap <= 1'b0;
    else wrap <= wrap_hit;
`else
  assign wrap = 1'b0;
`endif
endmodule

// File: tb/tb_counter_block.sv
// tb_counter_block: randomized scoreboard bench for counter_block against a behavioural model
module tb_counter_block;
  typedef struct {
    logic [31:0] nxt;
    logic [31:0] q;
    logic [15:0] cnt;
    logic        wr;
  } exp_t;
`ifdef COUNTER_BLOCK_WRAP_DETECT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] key = '0, prev_value = '0;
  logic enable = 1'b0, new_message = 1'b0;
  logic [31:0] counter_next, counter_q;
  logic [15:0] block_cnt;
  logic wrap;
  int vectors = 0, errors = 0;
  exp_t sb[$];
  logic [31:0] m_q = '0;
  logic [15:0] m_cnt = '0;
  counter_block dut (
    .clk(clk), .rst_n(rst_n), .key(key), .prev_value(prev_value),
    .enable(enable), .new_message(new_message), .counter_next(counter_next),
    .counter_q(counter_q), .block_cnt(block_cnt), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // one block: drive inputs, advance the model, queue the expected response
  task automatic step(input logic en, input logic nm, input logic [31:0] k, input logic [31:0] pv);
    exp_t e;
    enable = en; new_message = nm; key = k; prev_value = pv;
    e.nxt = !en ? pv : nm ? k : pv + 32'd1;
    if (en) begin
      m_q = e.nxt;
      m_cnt = nm ? 16'd1 : (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end
    e.q = m_q; e.cnt = m_cnt;
    e.wr = WRAP_EN && en && !nm && pv == 32'hFFFF_FFFF;
    sb.push_back(e);
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_q"}, counter_q, 32'd0);
    chk({tag, "_cnt"}, 32'(block_cnt), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("counter_next", counter_next, e.nxt);
      #1;
      chk("counter_q", counter_q, e.q);
      chk("block_cnt", 32'(block_cnt), 32'(e.cnt));
      chk("wrap", 32'(wrap), 32'(e.wr));
    end
  end
  initial begin
    logic [31:0] pv;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 1, 32'hADACABAA, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, m_q);
    drain();
    chk("chain_q", counter_q, 32'hADACABAD);
    chk("chain_cnt", 32'(block_cnt), 32'd4);
    step(0, 1, 32'h0BAD_F00D, 32'h12345678);
    step(1, 0, 32'h0, 32'hFFFF_FFFF);
    step(0, 0, 32'h0, 32'h0);
    step(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: pv = $urandom;
        1: pv = 32'hFFFF_FFFF;
        default: pv = m_q;
      endcase
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7) == 0, $urandom, pv);
    end
    step(1, 1, 32'h0, 32'h0);
    for (int i = 0; i < 65540; i++) begin
      enable = 1'b1; new_message = 1'b0; prev_value = m_q;
      if (i >= 65530) step(1, 0, 32'h0, m_q);
      else begin
        m_q = m_q + 32'd1;
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        @(negedge clk);
      end
    end
    drain();
    chk("sat_cnt", 32'(block_cnt), 32'h0000_FFFF);
    step(1, 1, 32'h5555_0000, 32'h0);
    step(1, 0, 32'h0, m_q);
    step(1, 0, 32'h0, m_q);
    drain();
    chk("mid_cnt", 32'(block_cnt), 32'd3);
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    m_q = '0; m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 32'h0, 32'h7FFF_FFFF);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
